// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the dcache/icache main-memory arbiter: FSM states,
// port identifiers and the saturating counter helper.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_D = 2'd1,
        ST_GRANT_I = 2'd2
    } arb_state_t;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr2_pick.sv
// Two-way round-robin pick: bit 0 is the dcache request, bit 1 the icache
// request; on a tie the port that was not granted last wins.
module arb_rr2_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == PORT_I) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one main-memory port between dcache (D) and icache (I).
// Optional MEM_ARB_PERF_CNT_EN adds saturating grant/wait performance counters.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [15:0]       d_grant_cnt,
    output logic [15:0]       i_grant_cnt,
    output logic [15:0]       i_wait_cnt
`endif
);

    arb_state_t state_q, state_d;
    logic       last_grant_q;
    logic       seen_busy_q;
    logic       d_req;
    logic [1:0] pick_gnt;
    logic       done;

    assign d_req      = d_read | d_write;
    assign d_readdata = mem_readdata;
    assign i_readdata = mem_readdata;

    arb_rr2_pick u_pick (
        .req  ({i_read, d_req}),
        .last (last_grant_q),
        .gnt  (pick_gnt)
    );

    // The granted requester stays stalled until memory has raised and then
    // dropped busywait, so a slow-to-respond memory cannot finish it early.
    always_comb begin
        state_d       = state_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        d_busywait    = d_req;
        i_busywait    = i_read;
        done          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_gnt[0]) begin
                    state_d = ST_GRANT_D;
                end else if (pick_gnt[1]) begin
                    state_d = ST_GRANT_I;
                end
            end
            ST_GRANT_D: begin
                mem_read      = d_read;
                mem_write     = d_write;
                mem_address   = d_address;
                mem_writedata = d_writedata;
                d_busywait    = mem_busywait | ~seen_busy_q;
                done          = seen_busy_q & ~mem_busywait;
                if (done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT_I: begin
                mem_read    = i_read;
                mem_address = i_address;
                i_busywait  = mem_busywait | ~seen_busy_q;
                done        = seen_busy_q & ~mem_busywait;
                if (done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_I;
            seen_busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (done) begin
                last_grant_q <= (state_q == ST_GRANT_I) ? PORT_I : PORT_D;
                seen_busy_q  <= 1'b0;
            end else if (state_q != ST_IDLE && mem_busywait) begin
                seen_busy_q <= 1'b1;
            end
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            d_grant_cnt <= '0;
            i_grant_cnt <= '0;
            i_wait_cnt  <= '0;
        end else begin
            if (done && state_q == ST_GRANT_D) begin
                d_grant_cnt <= sat_inc(d_grant_cnt);
            end
            if (done && state_q == ST_GRANT_I) begin
                i_grant_cnt <= sat_inc(i_grant_cnt);
            end
            if (i_read && state_q != ST_GRANT_I) begin
                i_wait_cnt <= sat_inc(i_wait_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: cache requesters, a latency-programmable memory,
// a transaction-level reference of the bus ownership and directed/random stimulus.
module tb_mem_bus_arbiter;

    localparam int BOUND = 18;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        d_read = 1'b0, d_write = 1'b0;
    logic [5:0]  d_address = '0;
    logic [31:0] d_writedata = '0;
    logic [31:0] d_readdata;
    logic        d_busywait;
    logic        i_read = 1'b0;
    logic [5:0]  i_address = '0;
    logic [31:0] i_readdata;
    logic        i_busywait;
    logic        mem_read, mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] d_grant_cnt, i_grant_cnt, i_wait_cnt;
`endif

    int total = 0;
    int bad = 0;

    mem_bus_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_readdata    (d_readdata),
        .d_busywait    (d_busywait),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_readdata    (i_readdata),
        .i_busywait    (i_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .d_grant_cnt   (d_grant_cnt),
        .i_grant_cnt   (i_grant_cnt),
        .i_wait_cnt    (i_wait_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int a);
        return 32'hA500_0000 ^ (a * 32'h0001_0203);
    endfunction

    // Memory: busywait rises the edge after a request appears, stays high
    // for the latency, read data is registered as busywait falls.
    bit          rand_lat = 1'b0;
    int          fixed_lat = 3;
    logic        mb_busy, mb_fin;
    int          mb_cnt;
    logic [31:0] mb_rdata;
    logic [31:0] mem_arr [64];

    assign mem_busywait = mb_busy;
    assign mem_readdata = mb_rdata;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mb_busy  <= 1'b0;
            mb_fin   <= 1'b0;
            mb_cnt   <= 0;
            mb_rdata <= '0;
            for (int a = 0; a < 64; a++) mem_arr[a] <= init_val(a);
        end else if (mem_read || mem_write) begin
            if (!mb_busy && !mb_fin) begin
                mb_busy <= 1'b1;
                mb_cnt  <= rand_lat ? int'($urandom_range(5, 1)) - 1 : fixed_lat - 1;
            end else if (mb_busy) begin
                if (mb_cnt == 0) begin
                    mb_busy <= 1'b0;
                    mb_fin  <= 1'b1;
                    if (mem_write) mem_arr[mem_address] <= mem_writedata;
                    else mb_rdata <= mem_arr[mem_address];
                end else begin
                    mb_cnt <= mb_cnt - 1;
                end
            end
        end else begin
            mb_fin <= 1'b0;
        end
    end

    // Reference: who owns the bus (-1 none, 0 D, 1 I), who finished last,
    // and whether memory has acknowledged the current access yet.
    int m_owner = -1;
    bit m_last = 1'b1;
    bit m_seen = 1'b0;
    int m_dg = 0, m_ig = 0, m_iw = 0;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_owner <= -1;
            m_last  <= 1'b1;
            m_seen  <= 1'b0;
            m_dg    <= 0;
            m_ig    <= 0;
            m_iw    <= 0;
        end else begin
            if (i_read && m_owner != 1 && m_iw < 65535) m_iw <= m_iw + 1;
            if (m_owner < 0) begin
                if ((d_read || d_write) && i_read) m_owner <= m_last ? 0 : 1;
                else if (d_read || d_write) m_owner <= 0;
                else if (i_read) m_owner <= 1;
            end else if (m_seen && !mem_busywait) begin
                if (m_owner == 0 && m_dg < 65535) m_dg <= m_dg + 1;
                if (m_owner == 1 && m_ig < 65535) m_ig <= m_ig + 1;
                m_last  <= (m_owner == 1);
                m_owner <= -1;
                m_seen  <= 1'b0;
            end else if (mem_busywait) begin
                m_seen <= 1'b1;
            end
        end
    end

    function automatic logic [63:0] pk(input logic r, input logic w, input logic [5:0] a,
                                       input logic [31:0] wd, input logic db, input logic ib);
        return {22'd0, r, w, a, wd, db, ib};
    endfunction

    always @(negedge CLK) begin
        logic [63:0] exp;
        case (m_owner)
            0:       exp = pk(d_read, d_write, d_address, d_writedata,
                              mem_busywait | !m_seen, i_read);
            1:       exp = pk(i_read, 1'b0, i_address, 32'd0,
                              d_read | d_write, mem_busywait | !m_seen);
            default: exp = pk(1'b0, 1'b0, 6'd0, 32'd0, d_read | d_write, i_read);
        endcase
        check("bus", pk(mem_read, mem_write, mem_address, mem_writedata, d_busywait, i_busywait), exp);
        check("readdata", {d_readdata, i_readdata}, {mem_readdata, mem_readdata});
`ifdef MEM_ARB_PERF_CNT_EN
        check("perf", 64'({d_grant_cnt, i_grant_cnt, i_wait_cnt}),
              64'({m_dg[15:0], m_ig[15:0], m_iw[15:0]}));
`endif
    end

    // Requesters
    bit          d_act = 1'b0, i_act = 1'b0;
    logic [5:0]  d_addr_h, i_addr_h;
    logic [31:0] d_wdata_h;
    logic [31:0] ref_arr [64];
    int          d_run, mrd_run, i_run;
    int          last_d_run, last_mrd_run, last_i_run;
    logic        s_mrd;
    logic [5:0]  s_maddr;
    int          order[$];

    task automatic issue_d(input bit wr, input logic [5:0] a, input logic [31:0] dta);
        d_read = !wr;
        d_write = wr;
        d_address = a;
        d_writedata = dta;
        d_addr_h = a;
        d_wdata_h = dta;
        d_act = 1'b1;
        d_run = 0;
        mrd_run = 0;
    endtask

    task automatic issue_i(input logic [5:0] a);
        i_read = 1'b1;
        i_address = a;
        i_addr_h = a;
        i_act = 1'b1;
        i_run = 0;
    endtask

    task automatic cycle_step();
        logic dbw, ibw;
        logic [31:0] drd, ird;
        @(negedge CLK);
        dbw = d_busywait;
        ibw = i_busywait;
        drd = d_readdata;
        ird = i_readdata;
        s_mrd = mem_read;
        s_maddr = mem_address;
        if (d_act && dbw) d_run++;
        if (d_act && s_mrd) mrd_run++;
        if (i_act && ibw) i_run++;
        @(posedge CLK);
        #1;
        if (d_act && !dbw) begin
            if (d_read) check("d_rdata", 64'(drd), 64'(ref_arr[d_addr_h]));
            else ref_arr[d_addr_h] = d_wdata_h;
            last_d_run = d_run;
            last_mrd_run = mrd_run;
            d_act = 1'b0;
            d_read = 1'b0;
            d_write = 1'b0;
            order.push_back(0);
        end
        if (i_act && !ibw) begin
            check("i_rdata", 64'(ird), 64'(ref_arr[i_addr_h]));
            check("i_wait_bound", 64'(i_run > BOUND), 64'd0);
            last_i_run = i_run;
            i_act = 1'b0;
            i_read = 1'b0;
            order.push_back(1);
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget && (d_act || i_act); c++) cycle_step();
        check("wait_idle_timeout", 64'(d_act || i_act), 64'd0);
        d_act = 1'b0; i_act = 1'b0;
        d_read = 1'b0; d_write = 1'b0; i_read = 1'b0;
    endtask

    function automatic logic [63:0] ord_code();
        logic [63:0] bits = '0;
        foreach (order[k]) bits = (bits << 1) | 64'(order[k]);
        return (64'(order.size()) << 8) | bits;
    endfunction

    task automatic drop_requests();
        d_act = 1'b0; i_act = 1'b0;
        d_read = 1'b0; d_write = 1'b0; i_read = 1'b0;
        for (int a = 0; a < 64; a++) ref_arr[a] = init_val(a);
    endtask

    task automatic pulse_reset();
        RESET = 1'b0;
        drop_requests();
        @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        int dn, in_;
        drop_requests();
        repeat (2) @(posedge CLK);
        #1;
        check("reset_outputs", pk(mem_read, mem_write, mem_address, mem_writedata, d_busywait, i_busywait), 64'd0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // D read, latency 20
        fixed_lat = 20;
        issue_d(1'b0, 6'h05, 32'd0);
        cycle_step();
        check("t1_idle_latency", 64'(s_mrd), 64'd0);
        cycle_step();
        check("t1_grant", 64'({s_mrd, s_maddr}), 64'({1'b1, 6'h05}));
        wait_idle(100);
        check("t1_d_stall_len", 64'(last_d_run), 64'd22);
        check("t1_mem_read_len", 64'(last_mrd_run), 64'd22);
        cycle_step();
        check("t1_idle_after", 64'(s_mrd), 64'd0);

        // simultaneous I read and D write after reset
        pulse_reset();
        fixed_lat = 3;
        order.delete();
        issue_i(6'h10);
        issue_d(1'b1, 6'h03, 32'hDEAD_BEEF);
        wait_idle(100);
        check("t2_order", ord_code(), 64'h201);
        check("t2_d_stall_len", 64'(last_d_run), 64'd5);
        check("t2_i_stall_len", 64'(last_i_run), 64'd11);

        // both continuously requesting: D,I,D,I
        order.delete();
        issue_d(1'b0, 6'h03, 32'd0);
        issue_i(6'h04);
        dn = 1; in_ = 1;
        for (int c = 0; c < 300 && order.size() < 4; c++) begin
            cycle_step();
            if (!d_act && dn < 2) begin issue_d(1'b1, 6'h07, 32'h1234_5678); dn++; end
            if (!i_act && in_ < 2) begin issue_i(6'h07); in_++; end
        end
        wait_idle(100);
        check("t3_alternate", ord_code(), 64'h405);

        // I arrives during GRANT_D: no preemption
        order.delete();
        fixed_lat = 4;
        issue_d(1'b0, 6'h21, 32'd0);
        repeat (3) cycle_step();
        issue_i(6'h2A);
        wait_idle(100);
        check("t4_no_preempt", ord_code(), 64'h201);

        // reset in the middle of GRANT_I
        fixed_lat = 5;
        issue_i(6'h11);
        repeat (3) cycle_step();
        #2;
        RESET = 1'b0;
        #1;
        check("t5_reset_drop", 64'({mem_read, mem_write}), 64'd0);
        drop_requests();
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        order.delete();
        issue_i(6'h12);
        issue_d(1'b0, 6'h13, 32'd0);
        wait_idle(100);
        check("t5_first_tie_d", ord_code(), 64'h201);

        // random traffic with random memory latency
        rand_lat = 1'b1;
        for (int c = 0; c < 600; c++) begin
            cycle_step();
            if (!d_act && $urandom_range(2, 0) == 0)
                issue_d(1'($urandom_range(1, 0)), 6'($urandom_range(63, 0)), $urandom);
            if (!i_act && $urandom_range(2, 0) == 0)
                issue_i(6'($urandom_range(63, 0)));
        end
        wait_idle(200);
        repeat (2) cycle_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
